// File: rtl/ahb_master_arbiter_if.sv
// rtl/ahb_master_arbiter_if.sv - request/response channels and AHB-Lite master bus bundle
interface ahb_master_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    // Internal request channels, one slice per master
    logic [NUM_MASTERS-1:0]        req_valid;
    logic [NUM_MASTERS*ADDR_W-1:0] req_addr;
    logic [NUM_MASTERS-1:0]        req_write;
    logic [NUM_MASTERS*3-1:0]      req_size;
    logic [NUM_MASTERS*DATA_W-1:0] req_wdata;
    logic [NUM_MASTERS-1:0]        req_ready;

    // Per-channel completion, data and error shared across channels
    logic [NUM_MASTERS-1:0]        rsp_valid;
    logic [DATA_W-1:0]             rsp_rdata;
    logic                          rsp_err;

    // External AHB-Lite master port
    logic [ADDR_W-1:0]             HADDR;
    logic [1:0]                    HTRANS;
    logic                          HWRITE;
    logic [2:0]                    HSIZE;
    logic [2:0]                    HBUST;
    logic [DATA_W-1:0]             HWDATA;
    logic [DATA_W-1:0]             HRDATA;
    logic                          HREADY;
    logic [1:0]                    HRESP;

    // Arbiter side
    modport master (
        input  req_valid, req_addr, req_write, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBUST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    // Requesters and bus slave side
    modport slave (
        output req_valid, req_addr, req_write, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBUST, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - multi-channel AHB-Lite master with pipelined arbitration
module ahb_master_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_master_arbiter_if.master bus
);
    localparam int         IDX_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_ERROR   = 2'b01;

    // Data-phase tracker: IDLE = no transfer awaiting completion
    typedef enum logic {PH_IDLE, PH_DATA} phase_t;

    phase_t             phase_q, phase_d;
    logic [IDX_W-1:0]   dp_owner_q, dp_owner_d;
    logic               dp_write_q, dp_write_d;
    logic [DATA_W-1:0]  hwdata_q, hwdata_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    // Address-phase hold: a NONSEQ stalled by HREADY=0 keeps its owner
    logic               pend_q;
    logic [IDX_W-1:0]   pend_owner_q;
    logic [ADDR_W-1:0]  haddr_q;
    logic               hwrite_q;
    logic [2:0]         hsize_q;

    logic               dp_valid;
    logic               err_first;
    logic               dp_done;
    logic               any_req;
    logic               addr_active;
    logic               accept;
    logic               hi_found;
    logic [IDX_W-1:0]   hi_win;
    logic [IDX_W-1:0]   lo_win;
    logic [IDX_W-1:0]   arb_win;
    logic [IDX_W-1:0]   win;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_write;
    logic [2:0]         sel_size;
    logic [DATA_W-1:0]  sel_wdata;
    logic [ADDR_W-1:0]  haddr_d;
    logic               hwrite_d;
    logic [2:0]         hsize_d;

    assign dp_valid    = (phase_q == PH_DATA);
    assign err_first   = dp_valid && !bus.HREADY && (bus.HRESP == RESP_ERROR);
    assign dp_done     = HRESETn && dp_valid && bus.HREADY;
    assign any_req     = |bus.req_valid;
    assign addr_active = HRESETn && any_req && !err_first;
    assign accept      = addr_active && bus.HREADY;

    // Winner select: lowest requester, or first requester above rr_ptr with wrap
    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                lo_win = IDX_W'(i);
                if (IDX_W'(i) > rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_win   = IDX_W'(i);
                end
            end
        end
        arb_win = ((ARB_MODE == 1) && hi_found) ? hi_win : lo_win;
        win     = pend_q ? pend_owner_q : arb_win;
    end

    // Route the winning channel's fields onto the address phase
    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (IDX_W'(i) == win) begin
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_write = bus.req_write[i];
                sel_size  = bus.req_size[i*3 +: 3];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
        haddr_d  = addr_active ? sel_addr  : haddr_q;
        hwrite_d = addr_active ? sel_write : hwrite_q;
        hsize_d  = addr_active ? sel_size  : hsize_q;
    end

    // Bus outputs and per-channel handshakes
    always_comb begin
        bus.HTRANS    = addr_active ? TRANS_NONSEQ : TRANS_IDLE;
        bus.HADDR     = haddr_d;
        bus.HWRITE    = hwrite_d;
        bus.HSIZE     = hsize_d;
        bus.HBUST     = 3'b000;
        bus.HWDATA    = hwdata_q;
        bus.rsp_rdata = (dp_done && !dp_write_q) ? bus.HRDATA : '0;
        bus.rsp_err   = dp_done && (bus.HRESP == RESP_ERROR);
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.req_ready[i] = accept  && (win == IDX_W'(i));
            bus.rsp_valid[i] = dp_done && (dp_owner_q == IDX_W'(i));
        end
    end

    // Next data-phase state: acceptance overrides completion for back-to-back
    always_comb begin
        phase_d    = phase_q;
        dp_owner_d = dp_owner_q;
        dp_write_d = dp_write_q;
        hwdata_d   = hwdata_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            phase_d    = PH_DATA;
            dp_owner_d = win;
            dp_write_d = sel_write;
            hwdata_d   = sel_wdata;
            if (ARB_MODE == 1) begin
                rr_ptr_d = win;
            end
        end else if (dp_done) begin
            phase_d = PH_IDLE;
        end
    end

    // Data-phase state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            phase_q    <= PH_IDLE;
            dp_owner_q <= '0;
            dp_write_q <= 1'b0;
            hwdata_q   <= '0;
            rr_ptr_q   <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            phase_q    <= phase_d;
            dp_owner_q <= dp_owner_d;
            dp_write_q <= dp_write_d;
            hwdata_q   <= hwdata_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Remember the last address phase so it holds while idle or stalled
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q       <= 1'b0;
            pend_owner_q <= '0;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
        end else begin
            pend_q       <= addr_active && !bus.HREADY;
            pend_owner_q <= win;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
        end
    end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb/tb_ahb_master_arbiter.sv - directed bench for ahb_master_arbiter in both arbitration modes
module tb_ahb_master_arbiter;
    logic HCLK;
    logic HRESETn;
    int   checks;
    int   errors;

    ahb_master_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus0 ();
    ahb_master_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus1 ();

    assign bus1.req_valid = bus0.req_valid;
    assign bus1.req_addr  = bus0.req_addr;
    assign bus1.req_write = bus0.req_write;
    assign bus1.req_size  = bus0.req_size;
    assign bus1.req_wdata = bus0.req_wdata;
    assign bus1.HRDATA    = bus0.HRDATA;
    assign bus1.HREADY    = bus0.HREADY;
    assign bus1.HRESP     = bus0.HRESP;

    ahb_master_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut0 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus0)
    );

    ahb_master_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut1 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus1)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic set_req(input int ch, input logic v, input logic [31:0] a,
                           input logic w, input logic [31:0] d);
        bus0.req_valid[ch]          = v;
        bus0.req_addr[ch*32 +: 32]  = a;
        bus0.req_write[ch]          = w;
        bus0.req_size[ch*3 +: 3]    = 3'b010;
        bus0.req_wdata[ch*32 +: 32] = d;
    endtask

    task automatic idle_all;
        bus0.req_valid = '0;
        bus0.req_addr  = '0;
        bus0.req_write = '0;
        bus0.req_size  = '0;
        bus0.req_wdata = '0;
        bus0.HRDATA    = '0;
        bus0.HREADY    = 1'b1;
        bus0.HRESP     = 2'b00;
    endtask

    task automatic test_reset;
        idle_all();
        HRESETn = 1'b0;
        set_req(0, 1'b1, 32'h0000_0040, 1'b1, 32'h1234_5678);
        set_req(1, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
        bus0.HRDATA = 32'hFFFF_FFFF;
        #1;
        checks++; if (bus0.HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %b want 00", bus0.HTRANS); end
        checks++; if (bus0.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", bus0.req_ready); end
        repeat (2) @(posedge HCLK);
        @(negedge HCLK); #1;
        checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b want 00", bus0.rsp_valid); end
        checks++; if (bus0.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", bus0.rsp_err); end
        checks++; if (bus0.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus0.rsp_rdata); end
        checks++; if (bus0.HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h want 0", bus0.HWDATA); end
        checks++; if (bus0.HBUST !== 3'b000) begin errors++; $display("FAIL rst_hbust: got %b want 000", bus0.HBUST); end
        checks++; if (bus1.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready_rr: got %b want 00", bus1.req_ready); end
        @(negedge HCLK);
        idle_all();
        HRESETn = 1'b1;
    endtask

    task automatic test_single_read;
        @(negedge HCLK);
        idle_all();
        set_req(0, 1'b1, 32'h0000_1000, 1'b0, 32'h0);
        #1;
        checks++; if (bus0.HTRANS !== 2'b10) begin errors++; $display("FAIL sr_htrans: got %b want 10", bus0.HTRANS); end
        checks++; if (bus0.HADDR !== 32'h0000_1000) begin errors++; $display("FAIL sr_haddr: got %h want 00001000", bus0.HADDR); end
        checks++; if (bus0.HWRITE !== 1'b0) begin errors++; $display("FAIL sr_hwrite: got %b want 0", bus0.HWRITE); end
        checks++; if (bus0.HSIZE !== 3'b010) begin errors++; $display("FAIL sr_hsize: got %b want 010", bus0.HSIZE); end
        checks++; if (bus0.req_ready !== 2'b01) begin errors++; $display("FAIL sr_ready: got %b want 01", bus0.req_ready); end
        checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL sr_rsp_early: got %b want 00", bus0.rsp_valid); end
        @(negedge HCLK);
        set_req(0, 1'b0, 32'h0000_1000, 1'b0, 32'h0);
        bus0.HRDATA = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus0.rsp_valid !== 2'b01) begin errors++; $display("FAIL sr_rsp_valid: got %b want 01", bus0.rsp_valid); end
        checks++; if (bus0.rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_rdata: got %h want deadbeef", bus0.rsp_rdata); end
        checks++; if (bus0.rsp_err !== 1'b0) begin errors++; $display("FAIL sr_err: got %b want 0", bus0.rsp_err); end
        checks++; if (bus0.HTRANS !== 2'b00) begin errors++; $display("FAIL sr_idle: got %b want 00", bus0.HTRANS); end
        checks++; if (bus0.HADDR !== 32'h0000_1000) begin errors++; $display("FAIL sr_haddr_hold: got %h want 00001000", bus0.HADDR); end
        @(negedge HCLK);
        idle_all();
        #1;
        checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL sr_rsp_pulse: got %b want 00", bus0.rsp_valid); end
    endtask

    task automatic test_back_to_back;
        @(negedge HCLK);
        idle_all();
        set_req(0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0011);
        set_req(1, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        #1;
        checks++; if (bus0.HADDR !== 32'h0000_0100) begin errors++; $display("FAIL b2b_haddr0: got %h want 00000100", bus0.HADDR); end
        checks++; if (bus0.HWRITE !== 1'b1) begin errors++; $display("FAIL b2b_hwrite0: got %b want 1", bus0.HWRITE); end
        checks++; if (bus0.req_ready !== 2'b01) begin errors++; $display("FAIL b2b_ready0: got %b want 01", bus0.req_ready); end
        @(negedge HCLK);
        set_req(0, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_0011);
        #1;
        checks++; if (bus0.HADDR !== 32'h0000_0200) begin errors++; $display("FAIL b2b_haddr1: got %h want 00000200", bus0.HADDR); end
        checks++; if (bus0.HTRANS !== 2'b10) begin errors++; $display("FAIL b2b_htrans1: got %b want 10", bus0.HTRANS); end
        checks++; if (bus0.req_ready !== 2'b10) begin errors++; $display("FAIL b2b_ready1: got %b want 10", bus0.req_ready); end
        checks++; if (bus0.HWDATA !== 32'h0000_0011) begin errors++; $display("FAIL b2b_hwdata: got %h want 00000011", bus0.HWDATA); end
        checks++; if (bus0.rsp_valid !== 2'b01) begin errors++; $display("FAIL b2b_rsp0: got %b want 01", bus0.rsp_valid); end
        @(negedge HCLK);
        set_req(1, 1'b0, 32'h0000_0200, 1'b0, 32'h0);
        bus0.HRDATA = 32'h0000_0055;
        #1;
        checks++; if (bus0.rsp_valid !== 2'b10) begin errors++; $display("FAIL b2b_rsp1: got %b want 10", bus0.rsp_valid); end
        checks++; if (bus0.rsp_rdata !== 32'h0000_0055) begin errors++; $display("FAIL b2b_rdata: got %h want 00000055", bus0.rsp_rdata); end
    endtask

    task automatic test_contention;
        logic [1:0] want_fp [5];
        logic [1:0] want_rr [5];
        logic [1:0] want_rsp_fp [5];
        logic [1:0] want_rsp_rr [5];
        want_fp     = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        want_rr     = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        want_rsp_fp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        want_rsp_rr = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        @(negedge HCLK);
        idle_all();
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge HCLK);
            set_req(0, c < 4, 32'h0000_0A00, 1'b0, 32'h0);
            set_req(1, c < 4, 32'h0000_0B00, 1'b0, 32'h0);
            #1;
            checks++; if (bus0.req_ready !== want_fp[c]) begin errors++; $display("FAIL cont_fp_ready[%0d]: got %b want %b", c, bus0.req_ready, want_fp[c]); end
            checks++; if (bus1.req_ready !== want_rr[c]) begin errors++; $display("FAIL cont_rr_ready[%0d]: got %b want %b", c, bus1.req_ready, want_rr[c]); end
            checks++; if (bus0.rsp_valid !== want_rsp_fp[c]) begin errors++; $display("FAIL cont_fp_rsp[%0d]: got %b want %b", c, bus0.rsp_valid, want_rsp_fp[c]); end
            checks++; if (bus1.rsp_valid !== want_rsp_rr[c]) begin errors++; $display("FAIL cont_rr_rsp[%0d]: got %b want %b", c, bus1.rsp_valid, want_rsp_rr[c]); end
            if (c == 1) begin
                checks++; if (bus1.HADDR !== 32'h0000_0B00) begin errors++; $display("FAIL cont_rr_haddr: got %h want 00000b00", bus1.HADDR); end
            end
        end
    endtask

    task automatic test_wait_states;
        @(negedge HCLK);
        idle_all();
        set_req(0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        set_req(1, 1'b1, 32'h0000_0400, 1'b0, 32'h0);
        #1;
        checks++; if (bus0.req_ready !== 2'b01) begin errors++; $display("FAIL ws_ready_t: got %b want 01", bus0.req_ready); end
        for (int w = 1; w <= 2; w++) begin
            @(negedge HCLK);
            set_req(0, 1'b0, 32'h0000_0300, 1'b0, 32'h0);
            bus0.HREADY = 1'b0;
            #1;
            checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL ws_rsp[%0d]: got %b want 00", w, bus0.rsp_valid); end
            checks++; if (bus0.req_ready !== 2'b00) begin errors++; $display("FAIL ws_ready[%0d]: got %b want 00", w, bus0.req_ready); end
            checks++; if (bus0.HTRANS !== 2'b10) begin errors++; $display("FAIL ws_htrans[%0d]: got %b want 10", w, bus0.HTRANS); end
            checks++; if (bus0.HADDR !== 32'h0000_0400) begin errors++; $display("FAIL ws_haddr[%0d]: got %h want 00000400", w, bus0.HADDR); end
        end
        @(negedge HCLK);
        bus0.HREADY = 1'b1;
        bus0.HRDATA = 32'h0000_3333;
        #1;
        checks++; if (bus0.rsp_valid !== 2'b01) begin errors++; $display("FAIL ws_rsp_t3: got %b want 01", bus0.rsp_valid); end
        checks++; if (bus0.rsp_rdata !== 32'h0000_3333) begin errors++; $display("FAIL ws_rdata: got %h want 00003333", bus0.rsp_rdata); end
        checks++; if (bus0.req_ready !== 2'b10) begin errors++; $display("FAIL ws_ready_t3: got %b want 10", bus0.req_ready); end
        @(negedge HCLK);
        set_req(1, 1'b0, 32'h0000_0400, 1'b0, 32'h0);
        bus0.HRDATA = 32'h0000_4444;
        #1;
        checks++; if (bus0.rsp_valid !== 2'b10) begin errors++; $display("FAIL ws_rsp_t4: got %b want 10", bus0.rsp_valid); end
        checks++; if (bus0.rsp_rdata !== 32'h0000_4444) begin errors++; $display("FAIL ws_rdata_t4: got %h want 00004444", bus0.rsp_rdata); end
    endtask

    task automatic test_error;
        @(negedge HCLK);
        idle_all();
        set_req(0, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_00AA);
        set_req(1, 1'b1, 32'h0000_0600, 1'b0, 32'h0);
        #1;
        checks++; if (bus0.req_ready !== 2'b01) begin errors++; $display("FAIL err_ready_t: got %b want 01", bus0.req_ready); end
        @(negedge HCLK);
        set_req(0, 1'b0, 32'h0000_0500, 1'b1, 32'h0000_00AA);
        bus0.HREADY = 1'b0;
        bus0.HRESP  = 2'b01;
        #1;
        checks++; if (bus0.HTRANS !== 2'b00) begin errors++; $display("FAIL err_htrans1: got %b want 00", bus0.HTRANS); end
        checks++; if (bus0.req_ready !== 2'b00) begin errors++; $display("FAIL err_ready1: got %b want 00", bus0.req_ready); end
        checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL err_rsp1: got %b want 00", bus0.rsp_valid); end
        checks++; if (bus0.HWDATA !== 32'h0000_00AA) begin errors++; $display("FAIL err_hwdata: got %h want 000000aa", bus0.HWDATA); end
        @(negedge HCLK);
        bus0.HREADY = 1'b1;
        #1;
        checks++; if (bus0.rsp_valid !== 2'b01) begin errors++; $display("FAIL err_rsp2: got %b want 01", bus0.rsp_valid); end
        checks++; if (bus0.rsp_err !== 1'b1) begin errors++; $display("FAIL err_flag2: got %b want 1", bus0.rsp_err); end
        checks++; if (bus0.req_ready !== 2'b10) begin errors++; $display("FAIL err_ready2: got %b want 10", bus0.req_ready); end
        checks++; if (bus0.HADDR !== 32'h0000_0600) begin errors++; $display("FAIL err_haddr2: got %h want 00000600", bus0.HADDR); end
        @(negedge HCLK);
        set_req(1, 1'b0, 32'h0000_0600, 1'b0, 32'h0);
        bus0.HRESP = 2'b00;
        #1;
        checks++; if (bus0.rsp_valid !== 2'b10) begin errors++; $display("FAIL err_rsp3: got %b want 10", bus0.rsp_valid); end
        checks++; if (bus0.rsp_err !== 1'b0) begin errors++; $display("FAIL err_flag3: got %b want 0", bus0.rsp_err); end
    endtask

    task automatic test_reset_mid;
        @(negedge HCLK);
        idle_all();
        set_req(0, 1'b1, 32'h0000_0700, 1'b0, 32'h0);
        #1;
        checks++; if (bus0.req_ready !== 2'b01) begin errors++; $display("FAIL rm_ready_t: got %b want 01", bus0.req_ready); end
        @(negedge HCLK);
        set_req(0, 1'b0, 32'h0000_0700, 1'b0, 32'h0);
        set_req(1, 1'b1, 32'h0000_0800, 1'b0, 32'h0);
        bus0.HREADY = 1'b0;
        #1;
        checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_rsp_wait: got %b want 00", bus0.rsp_valid); end
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        checks++; if (bus0.HTRANS !== 2'b00) begin errors++; $display("FAIL rm_htrans: got %b want 00", bus0.HTRANS); end
        checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_rsp_rst: got %b want 00", bus0.rsp_valid); end
        checks++; if (bus0.req_ready !== 2'b00) begin errors++; $display("FAIL rm_ready_rst: got %b want 00", bus0.req_ready); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        bus0.HREADY = 1'b1;
        set_req(0, 1'b1, 32'h0000_0900, 1'b0, 32'h0);
        #1;
        checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_rsp_after: got %b want 00", bus0.rsp_valid); end
        checks++; if (bus0.HTRANS !== 2'b10) begin errors++; $display("FAIL rm_htrans_after: got %b want 10", bus0.HTRANS); end
        checks++; if (bus0.req_ready !== 2'b01) begin errors++; $display("FAIL rm_ready_fp: got %b want 01", bus0.req_ready); end
        checks++; if (bus1.req_ready !== 2'b01) begin errors++; $display("FAIL rm_ready_rr: got %b want 01", bus1.req_ready); end
        checks++; if (bus1.rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_rsp_rr: got %b want 00", bus1.rsp_valid); end
        @(negedge HCLK);
        idle_all();
        #1;
        checks++; if (bus0.rsp_valid !== 2'b01) begin errors++; $display("FAIL rm_rsp_done: got %b want 01", bus0.rsp_valid); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        HRESETn = 1'b0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_contention();
        test_wait_states();
        test_error();
        test_reset_mid();
        repeat (2) @(negedge HCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Parametrised AHB-Lite bus interface unit that merges NUM_MASTERS internal request channels (default 2: instruction fetch and load/store) onto one shared AHB-Lite master port. It arbitrates in fixed-priority or round-robin mode and overlaps the next address phase with the current data phase. It returns per-channel responses carrying read data and error status. It sits between the IFU/MAU request logic and the single external CODE/DATA bus.

## Interface
- NUM_MASTERS, 2: number of request channels (1..8); channel index i occupies slice [i].
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- HCLK  in  1  clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_MASTERS  channel i requests a transfer; held with its fields until req_ready[i].
- req_addr  in  NUM_MASTERS*ADDR_W  request address per channel.
- req_write  in  NUM_MASTERS  1 = write, 0 = read.
- req_size  in  NUM_MASTERS*3  HSIZE encoding (000 byte, 001 half, 010 word).
- req_wdata  in  NUM_MASTERS*DATA_W  write data, sampled at acceptance.
- req_ready  out  NUM_MASTERS  one-hot or zero; request accepted this cycle.
- rsp_valid  out  NUM_MASTERS  one-hot or zero, 1-cycle pulse; transfer complete.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid (shared bus).
- rsp_err  out  1  transfer ended with ERROR, valid with rsp_valid.
- HADDR  out  ADDR_W  bus address.
- HTRANS  out  2  00 IDLE, 10 NONSEQ only.
- HWRITE  out  1  bus direction.
- HSIZE  out  3  bus transfer size.
- HBUST  out  3  constant 3'b000.
- HWDATA  out  DATA_W  data-phase write data (registered).
- HRDATA  in  DATA_W  read data.
- HREADY  in  1  transfer complete / bus free.
- HRESP  in  2  00 OKAY, 01 ERROR.

## Operation
- Arbitration (combinational): candidates = req_valid. The winner W is chosen as follows.
  - ARB_MODE 0: lowest set index.
  - ARB_MODE 1: first set index scanning from rr_ptr+1 upward, modulo NUM_MASTERS.
- Address phase: when any candidate exists and no ERROR first cycle is active, drive HTRANS=10 and HADDR/HWRITE/HSIZE from W. Otherwise drive HTRANS=00 and hold HADDR/HWRITE/HSIZE at their previous values.
- Acceptance: req_ready[W]=1 iff HTRANS=10 and HREADY=1. On acceptance:
  - dp_valid←1, dp_owner←W, dp_write←req_write[W].
  - HWDATA←req_wdata[W].
  - In mode 1, rr_ptr←W. rr_ptr changes only on acceptance.
- Data phase completion: when dp_valid=1 and HREADY=1:
  - rsp_valid[dp_owner]=1.
  - rsp_rdata=HRDATA for reads; don't-care for writes.
  - rsp_err=(HRESP==01).
  - dp_valid←0 unless a new acceptance occurs in the same cycle. Back-to-back acceptance keeps dp_valid=1 with the new owner.
- Error protocol: when HRESP=01 and HREADY=0 (first error cycle), force HTRANS=00 and assert no req_ready. The second cycle (HREADY=1, HRESP=01) completes the errored response. A pending request may be accepted in that second cycle.
- Wait states: while dp_valid=1 and HREADY=0, all outputs and state are held. Masters keep their requests stable.
- A channel may have at most one transfer in flight. Its logic must not re-assert req_valid before its rsp_valid.
- NUM_MASTERS=1: the arbiter degenerates to pass-through and rr_ptr is unused.

## Timing
- Reset (HRESETn=0, asynchronous): dp_valid=0, HWDATA=0, rr_ptr=NUM_MASTERS-1 (so channel 0 wins first). HTRANS is forced to 00 and req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 while HRESETn=0.
- Reset mid-transfer: the in-flight response is discarded with no rsp_valid. Bus resumes IDLE after deassertion.
- Latency with zero wait states:
  - Request accepted in cycle T.
  - rsp_valid in cycle T+1.
  - Sustained throughput is 1 transfer/cycle, including alternation between channels.
- Each wait state adds 1 cycle to rsp_valid. Acceptance of the next request is stalled for the same cycles.
- HWDATA is valid from T+1 until data-phase completion.
- Simultaneous completion of channel A and acceptance of channel B in one cycle is legal. rsp_valid[A] and req_ready[B] may both be 1, including A==B.

## Test plan
- Single read, ch0 addr 0x0000_1000, HRDATA=0xDEAD_BEEF, no waits -> req_ready[0] at T, rsp_valid[0] at T+1, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Back-to-back: ch0 write 0x100 (wdata 0x11) then ch1 read 0x200, no waits -> HADDR 0x100 at T, 0x200 at T+1, HWDATA=0x11 at T+1, rsp_valid 01 at T+1, 10 at T+2.
- Contention, both channels always requesting:
  - ARB_MODE 0 -> ch0 wins every cycle.
  - ARB_MODE 1 -> grants alternate 0,1,0,1 starting with ch0 after reset.
- Two wait states on a read of 0x300 -> rsp_valid at T+3, HADDR/HTRANS of the next pending request held stable, no req_ready until T+3.
- ERROR response on a write -> HTRANS=00 in first error cycle, rsp_valid with rsp_err=1 on the second cycle, next request accepted in that same cycle.
- HRESETn low for one cycle during a data phase with HREADY=0 -> no rsp_valid, HTRANS=00, ch0 granted first after release.
